// File: rtl/dmem_port_arbiter.sv
// Arbiter and sequencer for a dual-port data memory whose two ports share one write enable.
// Requester A drives port 1 and B drives port 2; conflicting writes are serialized with a round-robin grant.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    output logic [DATA_WIDTH-1:0] mem_wd1,
    output logic [DATA_WIDTH-1:0] mem_wd2,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd1,
    input  logic [DATA_WIDTH-1:0] mem_rd2,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t                prio_q;
    prio_t                prio_d;
    logic                 grant_a;
    logic                 grant_b;
    logic                 conflict;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Priority pointer, read responses and conflict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= PRIO_A;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            conflict_cnt <= '0;
        end else begin
            prio_q       <= prio_d;
            a_rvalid     <= grant_a && !a_we;
            b_rvalid     <= grant_b && !b_we;
            conflict_cnt <= cnt_d;
            if (grant_a && !a_we) begin
                a_rdata <= mem_rd1;
            end
            if (grant_b && !b_we) begin
                b_rdata <= mem_rd2;
            end
        end
    end

    // Grant decision; a shared WE makes read/write mixes and same-address writes unsafe together.
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        conflict = 1'b0;
        prio_d   = prio_q;
        cnt_d    = conflict_cnt;
        if (rst_n) begin
            if (a_valid && b_valid) begin
                if (!a_we && !b_we) begin
                    grant_a = 1'b1;
                    grant_b = 1'b1;
                end else if (a_we && b_we && (a_addr != b_addr)) begin
                    grant_a = 1'b1;
                    grant_b = 1'b1;
                end else begin
                    conflict = 1'b1;
                    if (prio_q == PRIO_A) begin
                        grant_a = 1'b1;
                    end else begin
                        grant_b = 1'b1;
                    end
                end
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
        if (conflict) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
            if (conflict_cnt != {CNT_WIDTH{1'b1}}) begin
                cnt_d = conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Single-grant cases mirror the winner onto both ports so the shared WE writes one location.
    always_comb begin
        a_ready   = grant_a;
        b_ready   = grant_b;
        mem_addr1 = a_addr;
        mem_addr2 = b_addr;
        mem_wd1   = '0;
        mem_wd2   = '0;
        mem_we    = 1'b0;
        if (grant_a && grant_b) begin
            mem_wd1 = a_wdata;
            mem_wd2 = b_wdata;
            mem_we  = a_we;
        end else if (grant_a) begin
            mem_addr2 = a_addr;
            mem_wd1   = a_wdata;
            mem_wd2   = a_wdata;
            mem_we    = a_we;
        end else if (grant_b) begin
            mem_addr1 = b_addr;
            mem_wd1   = b_wdata;
            mem_wd2   = b_wdata;
            mem_we    = b_we;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed requests with hand-computed results,
// read responses checked by an independent monitor against queued expectations.
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst_n;
    logic          a_valid, a_we, a_ready, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_we, b_ready, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_wd1, mem_wd2, mem_rd1, mem_rd2;
    logic          mem_we;
    logic [CW-1:0] conflict_cnt;

    logic [DW-1:0] tb_mem [32];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    int            n_chk;
    int            n_fail;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_we(mem_we),
        .mem_rd1(mem_rd1), .mem_rd2(mem_rd2),
        .conflict_cnt(conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Dual-port memory with shared WE and combinational reads.
    assign mem_rd1 = tb_mem[mem_addr1];
    assign mem_rd2 = tb_mem[mem_addr2];
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr1] <= mem_wd1;
            tb_mem[mem_addr2] <= mem_wd2;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid) begin
                if (qa.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL a_rvalid: got unexpected pulse, data 0x%08h at %0t", a_rdata, $time);
                end else begin
                    chk("a_rdata", a_rdata, qa.pop_front());
                end
            end
            if (b_rvalid) begin
                if (qb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL b_rvalid: got unexpected pulse, data 0x%08h at %0t", b_rdata, $time);
                end else begin
                    chk("b_rdata", b_rdata, qb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic av, input logic awe, input logic [AW-1:0] aad,
                         input logic [DW-1:0] awd, input logic bv, input logic bwe,
                         input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        @(negedge clk);
        a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) begin
            tb_mem[i] <= 32'hAAAA0000 | 32'(i);
        end
        rst_n = 1'b0;
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 32'h5;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 5'd0; b_wdata = 32'h0;
        #1;
        // Reset state: grants forced off even with a request present.
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        repeat (2) @(posedge clk);
        idle();
        rst_n = 1'b1;

        // 1: A read alone.
        drive(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        qa.push_back(32'hAAAA0003);
        chk("t1_a_ready", 32'(a_ready), 32'h1);
        chk("t1_b_ready", 32'(b_ready), 32'h0);

        // 2: two reads together.
        drive(1'b1, 1'b0, 5'd4, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
        qa.push_back(32'hAAAA0004);
        qb.push_back(32'hAAAA0005);
        chk("t2_a_ready", 32'(a_ready), 32'h1);
        chk("t2_b_ready", 32'(b_ready), 32'h1);
        idle();
        chk("t2_cnt", 32'(conflict_cnt), 32'h0);

        // 3: two writes to distinct addresses in one edge.
        drive(1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 1'b1, 5'd9, 32'h22);
        chk("t3_ready_both", 32'({a_ready, b_ready}), 32'h3);
        chk("t3_mem_we", 32'(mem_we), 32'h1);
        chk("t3_addr2", 32'(mem_addr2), 32'h9);
        @(posedge clk); #1;
        chk("t3_mem7", tb_mem[7], 32'h11);
        chk("t3_mem9", tb_mem[9], 32'h22);
        chk("t3_mem8", tb_mem[8], 32'hAAAA0008);
        idle();
        chk("t3_cnt", 32'(conflict_cnt), 32'h0);

        // 4: write/read mix on the same address serializes, A first.
        reset_pulse();
        drive(1'b1, 1'b1, 5'd6, 32'h33, 1'b1, 1'b0, 5'd6, 32'h0);
        qb.push_back(32'h33);
        chk("t4_a_ready", 32'(a_ready), 32'h1);
        chk("t4_b_ready", 32'(b_ready), 32'h0);
        chk("t4_wd2_mirror", mem_wd2, 32'h33);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd6, 32'h0);
        chk("t4_b_ready2", 32'(b_ready), 32'h1);
        chk("t4_addr1_mirror", 32'(mem_addr1), 32'h6);
        idle();
        chk("t4_cnt", 32'(conflict_cnt), 32'h1);

        // 5: same-address writes alternate; counter saturates at 7.
        reset_pulse();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 5'd2, 32'hA5, 1'b1, 1'b1, 5'd2, 32'hB5);
            chk("t5_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t5_b_ready", 32'(b_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("t5_wd1", mem_wd1, (i % 2 == 0) ? 32'hA5 : 32'hB5);
            if (i == 3) begin
                @(posedge clk); #1;
                chk("t5_mem2", tb_mem[2], 32'hB5);
                chk("t5_cnt4", 32'(conflict_cnt), 32'h4);
            end
        end
        idle();
        chk("t5_cnt_sat", 32'(conflict_cnt), 32'h7);

        // 6: B write alone mirrors, then reset with A pending.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd8, 32'h44);
        chk("t6_addrs", 32'({mem_addr1, mem_addr2}), 32'h108);
        chk("t6_wd1", mem_wd1, 32'h44);
        chk("t6_wd2", mem_wd2, 32'h44);
        chk("t6_a_ready", 32'(a_ready), 32'h0);
        @(posedge clk); #1;
        chk("t6_mem8", tb_mem[8], 32'h44);
        drive(1'b1, 1'b0, 5'd10, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        qa.push_back(32'hAAAA000A);
        drive(1'b1, 1'b1, 5'd12, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t6_pre_rvalid", 32'(a_rvalid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", 32'(a_rvalid), 32'h0);
        chk("t6_rst_ready", 32'(a_ready), 32'h0);
        chk("t6_rst_we", 32'(mem_we), 32'h0);
        chk("t6_rst_cnt", 32'(conflict_cnt), 32'h0);
        @(posedge clk); #1;
        chk("t6_mem12_held", tb_mem[12], 32'hAAAA000C);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_rel_ready", 32'(a_ready), 32'h1);
        chk("t6_rel_we", 32'(mem_we), 32'h1);
        @(posedge clk); #1;
        chk("t6_mem12", tb_mem[12], 32'h55);
        idle();

        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
